// File: rtl/pipe_hazard_unit.sv
// Operand forwarding, load-use interlock and branch-redirect flush control for an in-order pipeline.
// Forwarding is combinational (zero latency); controls are combinational from registered tags and FSM state.
// Backpressure: mem_stall freezes all state and raises stall_if/stall_id; ex_redirect is ignored while stalled.
module pipe_hazard_unit #(
    parameter int XLEN             = 32,
    parameter int NUM_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 1,
    parameter int REDIRECT_BUBBLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           id_valid,
    input  logic [4:0]                     id_rs1,
    input  logic [4:0]                     id_rs2,
    input  logic [4:0]                     id_rd,
    input  logic                           id_wen,
    input  logic                           id_is_load,
    input  logic [XLEN-1:0]                id_rs1_data,
    input  logic [XLEN-1:0]                id_rs2_data,
    input  logic [NUM_STAGES*XLEN-1:0]     stage_result,
    input  logic                           ex_redirect,
    input  logic                           mem_stall,
    output logic [XLEN-1:0]                fwd_rs1_data,
    output logic [XLEN-1:0]                fwd_rs2_data,
    output logic [$clog2(NUM_STAGES+1)-1:0] fwd_rs1_sel,
    output logic [$clog2(NUM_STAGES+1)-1:0] fwd_rs2_sel,
    output logic                           stall_if,
    output logic                           stall_id,
    output logic                           bubble_x,
    output logic                           flush_id,
    output logic [31:0]                    load_use_cnt
);

    localparam int SW = $clog2(NUM_STAGES + 1);

    // Destination tag of the instruction occupying one post-decode stage.
    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       ld;
    } tag_t;

    // Result of resolving one ID operand against the in-flight tags.
    typedef struct packed {
        logic [SW-1:0]   sel;
        logic [XLEN-1:0] dat;
        logic            early_ld;
    } fwd_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    tag_t   tag_q [NUM_STAGES];
    state_t state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] load_use_cnt_q, load_use_cnt_d;

    fwd_t rs1_fwd, rs2_fwd;
    logic load_use;

    // Youngest matching stage wins: scan oldest to youngest so the last hit is the smallest k.
    // x0 is never forwarded since writes to it are architecturally discarded.
    function automatic fwd_t resolve(input logic [4:0] idx, input logic [XLEN-1:0] rf_dat);
        fwd_t r;
        r.sel      = '0;
        r.dat      = rf_dat;
        r.early_ld = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (idx != 5'd0 && tag_q[k].vld && tag_q[k].rd == idx) begin
                r.sel      = SW'(k + 1);
                r.dat      = stage_result[k*XLEN +: XLEN];
                r.early_ld = tag_q[k].ld && (k < LOAD_READY_STAGE);
            end
        end
        return r;
    endfunction

    // Operand resolution and load-use detection.
    always_comb begin
        rs1_fwd      = resolve(id_rs1, id_rs1_data);
        rs2_fwd      = resolve(id_rs2, id_rs2_data);
        fwd_rs1_sel  = rs1_fwd.sel;
        fwd_rs2_sel  = rs2_fwd.sel;
        fwd_rs1_data = rs1_fwd.dat;
        fwd_rs2_data = rs2_fwd.dat;
        load_use     = id_valid && (rs1_fwd.early_ld || rs2_fwd.early_ld);
    end

    // Control FSM: redirect beats load-use; mem_stall overrides everything and freezes state.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        load_use_cnt_d = load_use_cnt_q;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        bubble_x       = 1'b0;
        flush_id       = 1'b0;
        if (mem_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_redirect) begin
                        flush_id = 1'b1;
                        bubble_x = 1'b1;
                        if (REDIRECT_BUBBLES > 1) begin
                            state_d     = FLUSH;
                            flush_cnt_d = 3'(REDIRECT_BUBBLES - 1);
                        end
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        bubble_x = 1'b1;
                        if (load_use_cnt_q != 32'hFFFF_FFFF) begin
                            load_use_cnt_d = load_use_cnt_q + 32'd1;
                        end
                    end
                end
                FLUSH: begin
                    flush_id = 1'b1;
                    bubble_x = 1'b1;
                    if (ex_redirect) begin
                        flush_cnt_d = 3'(REDIRECT_BUBBLES - 1);
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                        if (flush_cnt_q == 3'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // FSM, flush counter and statistics register; the comb block already holds them under mem_stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            flush_cnt_q    <= 3'd0;
            load_use_cnt_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            load_use_cnt_q <= load_use_cnt_d;
        end
    end

    // Tag pipeline advances with the datapath; a bubble into X enters as an invalid tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else if (!mem_stall) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                tag_q[k] <= tag_q[k-1];
            end
            if (bubble_x) begin
                tag_q[0] <= '0;
            end else begin
                tag_q[0] <= '{vld: id_valid && id_wen && (id_rd != 5'd0), rd: id_rd, ld: id_is_load};
            end
        end
    end

    assign load_use_cnt = load_use_cnt_q;

endmodule
